// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result-to-BCD converter.
//   - state_e            : converter FSM states
//   - ALU_W_DEFAULT      : default result width
//   - BCD_BLANK          : digit code shown for a blanked (overflowed) result
//   - BCD_ADD3_THRESHOLD : double-dabble correction threshold
package alu_pkg;

  localparam int unsigned ALU_W_DEFAULT      = 9;
  localparam logic [3:0]  BCD_BLANK          = 4'hF;
  localparam logic [3:0]  BCD_ADD3_THRESHOLD = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction.
//   din  [3:0] : BCD scratch digit before the shift
//   dout [3:0] : din + 3 when din >= 5, otherwise din
module bcd_add3
  import alu_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_ADD3_THRESHOLD) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/alu_result_bcd.sv
// alu_result_bcd: converts a signed W-bit ALU result into sign + 3 BCD digits
// using a sequential double-dabble (one bit per clock).
//   CLK, RST      : clock, synchronous active-high reset
//   START         : begin conversion of F/OF (sampled only when idle)
//   F [W-1:0]     : signed two's-complement result
//   OF            : overflow flag accompanying F
//   BUSY          : conversion in progress
//   DONE          : one-cycle pulse when SIGN/D2/D1/D0/OF_Q are updated
//   SIGN          : 1 = negative result
//   D2, D1, D0    : BCD hundreds, tens, ones
//   OF_Q          : overflow flag captured with the converted value
// Optional build macro ALU_OVF_BLANK_EN: an overflowed result is shown as
// blank digits (BCD_BLANK) with SIGN=0.
module alu_result_bcd
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] F,
  input  logic         OF,
  output logic         BUSY,
  output logic         DONE,
  output logic         SIGN,
  output logic [3:0]   D2,
  output logic [3:0]   D1,
  output logic [3:0]   D0,
  output logic         OF_Q
);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] mag_q, mag_d;
  logic [11:0]  bcd_q, bcd_d;
  logic [11:0]  bcd_adj;
  logic         sign_tmp_q, sign_tmp_d;
  logic         of_tmp_q, of_tmp_d;
  logic         sign_q, sign_d;
  logic [3:0]   d2_q, d2_d;
  logic [3:0]   d1_q, d1_d;
  logic [3:0]   d0_q, d0_d;
  logic         of_out_q, of_out_d;
  logic         done_q, done_d;

  // The hundreds lane never exceeds 9, so its adjusted MSB is always
  // shifted out of the scratch and dropped.
  logic         unused_bcd_msb;
  assign unused_bcd_msb = bcd_adj[11];

  for (genvar i = 0; i < 3; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*i +: 4]),
      .dout (bcd_adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_tmp_d = sign_tmp_q;
    of_tmp_d   = of_tmp_q;
    sign_d     = sign_q;
    d2_d       = d2_q;
    d1_d       = d1_q;
    d0_d       = d0_q;
    of_out_d   = of_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          sign_tmp_d = F[W-1];
          of_tmp_d   = OF;
          // Unsigned W-bit magnitude; the most negative value maps to 2^(W-1).
          mag_d      = F[W-1] ? (~F + W'(1)) : F;
          bcd_d      = '0;
          cnt_d      = 4'(W);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[10:0], mag_q[W-1]};
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        d2_d     = bcd_q[11:8];
        d1_d     = bcd_q[7:4];
        d0_d     = bcd_q[3:0];
        sign_d   = sign_tmp_q;
        of_out_d = of_tmp_q;
`ifdef ALU_OVF_BLANK_EN
        if (of_tmp_q) begin
          d2_d   = BCD_BLANK;
          d1_d   = BCD_BLANK;
          d0_d   = BCD_BLANK;
          sign_d = 1'b0;
        end
`else
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_tmp_q <= 1'b0;
      of_tmp_q   <= 1'b0;
      sign_q     <= 1'b0;
      d2_q       <= '0;
      d1_q       <= '0;
      d0_q       <= '0;
      of_out_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_tmp_q <= sign_tmp_d;
      of_tmp_q   <= of_tmp_d;
      sign_q     <= sign_d;
      d2_q       <= d2_d;
      d1_q       <= d1_d;
      d0_q       <= d0_d;
      of_out_q   <= of_out_d;
      done_q     <= done_d;
    end
  end

  assign BUSY = (state_q != ST_IDLE);
  assign DONE = done_q;
  assign SIGN = sign_q;
  assign D2   = d2_q;
  assign D1   = d1_q;
  assign D0   = d0_q;
  assign OF_Q = of_out_q;

endmodule

// File: doc/alu_result_bcd.md
ALU_RESULT_BCD -- requirements
Module: alu_result_bcd

Interface
REQ-001 Parameter W, default 9, result width in bits; legal range 4..10, so the magnitude always fits 3 BCD digits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request to convert current F/OF; sampled only in IDLE.
REQ-005 F  input  W  signed two's-complement result from the quintuplier stage.
REQ-006 OF  input  1  overflow flag from the quintuplier stage.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  one-cycle pulse when new outputs are valid.
REQ-009 SIGN  output  1  1 = negative result.
REQ-010 D2, D1, D0  output  4 each  BCD hundreds, tens and ones digits.
REQ-011 OF_Q  output  1  overflow flag latched with the converted value.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and FINISH; the encoding is free.
REQ-013 IDLE with START=1 at edge k: capture SIGN_tmp=F[W-1] and OF; capture MAG = |F| as a W-bit unsigned value (-2^(W-1) gives 2^(W-1)); clear the BCD scratch; set counter=W; go to SHIFT.
REQ-014 SHIFT, each edge: add 3 to every scratch digit >= 5, then shift {scratch, MAG} left by one; decrement counter; go to FINISH when the counter reaches 1.
REQ-015 FINISH: copy scratch to D2/D1/D0, SIGN_tmp to SIGN and OF to OF_Q; set DONE=1 for exactly one cycle; return to IDLE.
REQ-016 Latency: DONE is high in the cycle after edge k+W+1 (10 cycles after the START edge for W=9); BUSY is high from edge k until the FINISH edge.
REQ-017 START while BUSY=1 SHALL be ignored, with no queueing; F/OF changes during a conversion SHALL NOT affect it.
REQ-018 Outputs SIGN, Dx and OF_Q SHALL hold their last values between conversions, changing only on the FINISH edge.
REQ-019 Zero SHALL produce SIGN=0 and digits 0,0,0; no negative zero.
REQ-020 START asserted in the FINISH cycle SHALL be ignored; START held high SHALL restart in the first IDLE cycle, giving back-to-back conversions every W+2 cycles.

Reset
REQ-021 RST=1 at any edge SHALL force IDLE and clear BUSY, DONE, SIGN, D2, D1, D0, OF_Q, the counter and the scratch to 0, aborting any conversion in progress without a DONE pulse.
REQ-022 RST SHALL take priority over START in the same cycle.

Configuration
REQ-023 Macro ALU_OVF_BLANK_EN, defined: when the captured OF=1, FINISH SHALL load D2=D1=D0=4'hF (blank code) and SIGN=0; OF_Q=1; latency is unchanged.
REQ-024 ALU_OVF_BLANK_EN undefined: the digits and SIGN SHALL always reflect F, and OF only drives OF_Q.

Structure
REQ-025 Shared package alu_pkg SHALL hold the state encoding, the default W, the BCD blank code 4'hF and the add-3 threshold constant 5.
REQ-026 Sub-module bcd_add3 (4-bit in, 4-bit out: adds 3 when input >= 5) SHALL be instantiated once per digit.

Verification
REQ-027 F=9'sd125, OF=0, START pulse -> after 10 cycles DONE=1, SIGN=0, D2/D1/D0=1/2/5; BUSY high for exactly those cycles.
REQ-028 F=-9'sd30, i.e. 9'h1E2 (A=-6), START pulse -> SIGN=1, D=0/3/0; second test F=-9'sd256 -> SIGN=1, D=2/5/6.
REQ-029 START with F=45, then START with F=99 and F changed to 99 at cycle 3 of the conversion -> single DONE with D=0/4/5; no second DONE.
REQ-030 START with F=100, RST=1 at cycle 5 -> no DONE, all outputs 0, BUSY=0; a new START with F=7 gives D=0/0/7 after 10 cycles.
REQ-031 OF=1, F=9'h0C8, START -> with ALU_OVF_BLANK_EN defined: D=F/F/F, SIGN=0, OF_Q=1; without it: D=2/0/0, SIGN=0, OF_Q=1.
REQ-032 START held high for 30 cycles with F=0 -> DONE pulses at cycles 10, 21 and 32 relative to the first edge; D=0/0/0, SIGN=0.
